// File: rtl/axilite_mem_slave_if.sv
// AXI4-Lite bus bundle for axilite_mem_slave.
// Carries the five AXI4-Lite channels: AR/R (read) and AW/W/B (write).
// master modport: drives addresses, data, VALIDs and response READYs.
// slave modport : drives address/data READYs, read data and responses.
`timescale 1ns/1ps
interface axilite_mem_slave_if;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  modport master (
    output ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WVALID, BREADY,
    input  ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID
  );

  modport slave (
    input  ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WVALID, BREADY,
    output ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID
  );
endinterface

// File: rtl/axilite_mem_slave.sv
// AXI4-Lite slave backed by a DEPTH x 32-bit register memory.
// Ports:
//   clk      - single clock, all logic on posedge
//   reset    - asynchronous active-low reset
//   bus      - AXI4-Lite slave modport (AR/R/AW/W/B channels)
//   rd_count - completed read transactions (wraps at 8 bits)
//   wr_count - completed write transactions (wraps at 8 bits)
// Reads and writes run in independent FSMs. Out-of-range or misaligned
// addresses answer SLVERR; misses never touch memory.
`timescale 1ns/1ps
module axilite_mem_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned RD_WAIT   = 0
) (
  input  logic                clk,
  input  logic                reset,
  axilite_mem_slave_if.slave  bus,
  output logic [7:0]          rd_count,
  output logic [7:0]          wr_count
);

  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One past the last byte, kept 33 bits wide so a window at the top of
  // the address map does not overflow.
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} rd_state_t;
  typedef enum logic       {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;

  function automatic logic addr_hit(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) &&
           ({1'b0, addr} >= {1'b0, BASE_ADDR}) &&
           ({1'b0, addr} < END_ADDR);
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  logic [31:0] mem_q [DEPTH];

  rd_state_t   rd_state_q;
  logic [31:0] ar_addr_q;
  logic [3:0]  rd_cnt_q;
  logic        arready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [7:0]  rd_count_q;

  wr_state_t   wr_state_q;
  logic [31:0] aw_addr_q;
  logic [31:0] wdata_q;
  logic        aw_lat_q;
  logic        w_lat_q;
  logic        awready_q;
  logic        wready_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic [7:0]  wr_count_q;

  // Read FSM: accept AR, optional wait, then present data until R handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state_q <= R_IDLE;
      ar_addr_q  <= 32'h0;
      rd_cnt_q   <= 4'd0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'h0;
      rresp_q    <= 2'b00;
      rd_count_q <= 8'd0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (!arready_q) begin
            // READY comes up on the first edge after reset release.
            arready_q <= 1'b1;
          end else if (bus.ARVALID) begin
            ar_addr_q <= bus.ARADDR;
            arready_q <= 1'b0;
            if (RD_WAIT > 32'd0) begin
              rd_state_q <= R_WAIT;
              rd_cnt_q   <= 4'(RD_WAIT);
            end else begin
              rd_state_q <= R_DATA;
            end
          end
        end
        R_WAIT: begin
          if (rd_cnt_q == 4'd1) begin
            rd_state_q <= R_DATA;
          end else begin
            rd_cnt_q <= rd_cnt_q - 4'd1;
          end
        end
        R_DATA: begin
          if (!rvalid_q) begin
            // Load edge: a same-edge write to this word is not yet visible,
            // so the old memory value is returned.
            rvalid_q <= 1'b1;
            if (addr_hit(ar_addr_q)) begin
              rdata_q <= mem_q[addr_index(ar_addr_q)];
              rresp_q <= RESP_OKAY;
            end else begin
              rdata_q <= 32'h0;
              rresp_q <= RESP_SLVERR;
            end
          end else if (bus.RREADY) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= R_IDLE;
            rd_count_q <= rd_count_q + 8'd1;
          end
        end
        default: begin
          rd_state_q <= R_IDLE;
          arready_q  <= 1'b0;
          rvalid_q   <= 1'b0;
        end
      endcase
    end
  end

  // Write FSM and memory: latch AW and W independently, commit, respond.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_state_q <= W_IDLE;
      aw_addr_q  <= 32'h0;
      wdata_q    <= 32'h0;
      aw_lat_q   <= 1'b0;
      w_lat_q    <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      wr_count_q <= 8'd0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[IDX_W'(i)] <= 32'h0;
      end
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (aw_lat_q && w_lat_q) begin
            if (addr_hit(aw_addr_q)) begin
              mem_q[addr_index(aw_addr_q)] <= wdata_q;
            end
            wr_state_q <= W_RESP;
          end else begin
            if (!aw_lat_q) begin
              if (awready_q && bus.AWVALID) begin
                aw_addr_q <= bus.AWADDR;
                aw_lat_q  <= 1'b1;
                awready_q <= 1'b0;
              end else begin
                awready_q <= 1'b1;
              end
            end
            if (!w_lat_q) begin
              if (wready_q && bus.WVALID) begin
                wdata_q  <= bus.WDATA;
                w_lat_q  <= 1'b1;
                wready_q <= 1'b0;
              end else begin
                wready_q <= 1'b1;
              end
            end
          end
        end
        W_RESP: begin
          if (!bvalid_q) begin
            bvalid_q <= 1'b1;
            bresp_q  <= addr_hit(aw_addr_q) ? RESP_OKAY : RESP_SLVERR;
          end else if (bus.BREADY) begin
            bvalid_q   <= 1'b0;
            aw_lat_q   <= 1'b0;
            w_lat_q    <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= W_IDLE;
            wr_count_q <= wr_count_q + 8'd1;
          end
        end
        default: begin
          wr_state_q <= W_IDLE;
          awready_q  <= 1'b0;
          wready_q   <= 1'b0;
          bvalid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ARREADY = arready_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;
  assign bus.AWREADY = awready_q;
  assign bus.WREADY  = wready_q;
  assign bus.BVALID  = bvalid_q;
  assign bus.BRESP   = bresp_q;
  assign rd_count    = rd_count_q;
  assign wr_count    = wr_count_q;

endmodule
